// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-port SRAM between the IF and MEM
// pipeline stages. MEM has priority (a store beats a load); each access
// holds the strobes for SRAM_WAIT cycles and then spends one DONE cycle
// with the strobes released while the winner gets a one-cycle ready pulse.
// Optional feature: define MEMARB_STARVE_GUARD_EN to force an IF slot after
// STARVE_MAX consecutive MEM grants made while IF was waiting.
module mem_port_arbiter #(
    parameter int unsigned ADDR_W     = 32,
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned SRAM_WAIT  = 2,
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_ready,
    input  logic              mem_rd_req,
    input  logic              mem_wr_req,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_wdata,
    output logic [DATA_W-1:0] mem_rdata,
    output logic              mem_ready,
    output logic [ADDR_W-1:0] sram_addr,
    output logic [DATA_W-1:0] sram_wdata,
    input  logic [DATA_W-1:0] sram_rdata,
    output logic              sram_ce_n,
    output logic              sram_oe_n,
    output logic              sram_we_n,
    output logic              busy
);

    localparam int unsigned CNT_W = 4;

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_MEM_RD = 3'd1;
    localparam logic [2:0] S_MEM_WR = 3'd2;
    localparam logic [2:0] S_IF_RD  = 3'd3;
    localparam logic [2:0] S_DONE   = 3'd4;

    logic [2:0]        r_state;
    logic [2:0]        w_state_next;
    logic [CNT_W-1:0]  r_cnt;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic              r_owner_if;
    logic [DATA_W-1:0] r_if_rdata;
    logic [DATA_W-1:0] r_mem_rdata;
    logic              r_if_ready;
    logic              r_mem_ready;
    logic              r_ce_n;
    logic              r_oe_n;
    logic              r_we_n;
    logic              r_busy;

    logic              w_grant;
    logic              w_grant_if;
    logic              w_last;
    logic              w_access;
    logic              w_acc_next;
    logic              w_rd_next;
    logic              w_force_if;
    logic [ADDR_W-1:0] w_req_addr;
    logic [1:0]        w_unused_addr_lsbs;

`ifdef MEMARB_STARVE_GUARD_EN
    localparam int unsigned STV_W = $clog2(STARVE_MAX + 1);

    logic [STV_W-1:0] r_starve;

    // Count MEM grants that overtook a waiting IF; any other grant clears.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_starve <= '0;
        end else if (w_grant) begin
            if (!w_grant_if && if_req) begin
                r_starve <= r_starve + STV_W'(1);
            end else begin
                r_starve <= '0;
            end
        end
    end

    assign w_force_if = (r_starve == STV_W'(STARVE_MAX)) && if_req;
`else
    assign w_force_if = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    assign w_access = (r_state == S_MEM_RD) || (r_state == S_MEM_WR) || (r_state == S_IF_RD);

    // Next-state logic: IDLE arbitration and access countdown.
    always_comb begin
        w_state_next = r_state;
        w_grant      = 1'b0;
        w_grant_if   = 1'b0;
        w_last       = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_force_if) begin
                    w_state_next = S_IF_RD;
                    w_grant      = 1'b1;
                    w_grant_if   = 1'b1;
                end else if (mem_wr_req) begin
                    w_state_next = S_MEM_WR;
                    w_grant      = 1'b1;
                end else if (mem_rd_req) begin
                    w_state_next = S_MEM_RD;
                    w_grant      = 1'b1;
                end else if (if_req) begin
                    w_state_next = S_IF_RD;
                    w_grant      = 1'b1;
                    w_grant_if   = 1'b1;
                end
            end
            S_MEM_RD, S_MEM_WR, S_IF_RD: begin
                if (r_cnt == CNT_W'(1)) begin
                    w_last       = 1'b1;
                    w_state_next = S_DONE;
                end
            end
            S_DONE: begin
                w_state_next = S_IDLE;
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    assign w_acc_next = (w_state_next == S_MEM_RD) || (w_state_next == S_MEM_WR) ||
                        (w_state_next == S_IF_RD);
    assign w_rd_next  = (w_state_next == S_MEM_RD) || (w_state_next == S_IF_RD);
    assign w_req_addr = w_grant_if ? if_addr : mem_addr;
    assign w_unused_addr_lsbs = w_req_addr[1:0];

    // Latch the winning request and run the wait-state counter.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt      <= '0;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_owner_if <= 1'b0;
        end else if (w_grant) begin
            r_cnt      <= CNT_W'(SRAM_WAIT);
            r_addr     <= {2'b00, w_req_addr[ADDR_W-1:2]};
            r_wdata    <= mem_wdata;
            r_owner_if <= w_grant_if;
        end else if (w_access) begin
            r_cnt      <= r_cnt - CNT_W'(1);
        end
    end

    // Capture read data into the owner's register on the last wait cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_if_rdata  <= '0;
            r_mem_rdata <= '0;
        end else if (w_last && (r_state != S_MEM_WR)) begin
            if (r_owner_if) begin
                r_if_rdata  <= sram_rdata;
            end else begin
                r_mem_rdata <= sram_rdata;
            end
        end
    end

    // Registered strobes, ready pulses and busy, decoded from the next state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_ce_n      <= 1'b1;
            r_oe_n      <= 1'b1;
            r_we_n      <= 1'b1;
            r_busy      <= 1'b0;
            r_if_ready  <= 1'b0;
            r_mem_ready <= 1'b0;
        end else begin
            r_ce_n      <= !w_acc_next;
            r_oe_n      <= !w_rd_next;
            r_we_n      <= !(w_state_next == S_MEM_WR);
            r_busy      <= (w_state_next != S_IDLE);
            r_if_ready  <= (w_state_next == S_DONE) && r_owner_if;
            r_mem_ready <= (w_state_next == S_DONE) && !r_owner_if;
        end
    end

    assign if_rdata   = r_if_rdata;
    assign mem_rdata  = r_mem_rdata;
    assign if_ready   = r_if_ready;
    assign mem_ready  = r_mem_ready;
    assign sram_addr  = r_addr;
    assign sram_wdata = r_wdata;
    assign sram_ce_n  = r_ce_n;
    assign sram_oe_n  = r_oe_n;
    assign sram_we_n  = r_we_n;
    assign busy       = r_busy;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios followed by random traffic,
// all compared cycle by cycle against a transaction-level reference model.
module tb_mem_port_arbiter;

    localparam int unsigned AW   = 32;
    localparam int unsigned DW   = 32;
    localparam int unsigned W    = 2;
    localparam int unsigned SMAX = 4;
`ifdef MEMARB_STARVE_GUARD_EN
    localparam bit GUARD = 1'b1;
`else
    localparam bit GUARD = 1'b0;
`endif

    logic          clk;
    logic          rst;
    logic          if_req;
    logic [AW-1:0] if_addr;
    logic [DW-1:0] if_rdata;
    logic          if_ready;
    logic          mem_rd_req;
    logic          mem_wr_req;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;
    logic          mem_ready;
    logic [AW-1:0] sram_addr;
    logic [DW-1:0] sram_wdata;
    logic [DW-1:0] sram_rdata;
    logic          sram_ce_n;
    logic          sram_oe_n;
    logic          sram_we_n;
    logic          busy;

    mem_port_arbiter #(
        .ADDR_W(AW), .DATA_W(DW), .SRAM_WAIT(W), .STARVE_MAX(SMAX)
    ) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ready(if_ready),
        .mem_rd_req(mem_rd_req), .mem_wr_req(mem_wr_req), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
        .sram_addr(sram_addr), .sram_wdata(sram_wdata), .sram_rdata(sram_rdata),
        .sram_ce_n(sram_ce_n), .sram_oe_n(sram_oe_n), .sram_we_n(sram_we_n),
        .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Background contents of never-written SRAM words.
    function automatic logic [31:0] pattern(input logic [7:0] idx);
        if (idx == 8'd4) return 32'hE3A0_1005;
        return ({24'd0, idx} * 32'h9E37_79B1) + 32'h0000_1234;
    endfunction

    // Behavioural SRAM: combinational read, write on clock while ce/we low.
    bit          sram_vld [256];
    logic [31:0] sram_dat [256];
    always @(posedge clk) begin
        if (!sram_ce_n && !sram_we_n) begin
            sram_vld[sram_addr[7:0]] <= 1'b1;
            sram_dat[sram_addr[7:0]] <= sram_wdata;
        end
    end
    assign sram_rdata = sram_vld[sram_addr[7:0]] ? sram_dat[sram_addr[7:0]]
                                                 : pattern(sram_addr[7:0]);

    // Reference model: one transaction at a time, m_left counts the cycles
    // left until the arbiter is idle again (W access cycles, then DONE).
    int          m_left;
    int          m_owner;      // 0 = IF, 1 = MEM load, 2 = MEM store
    logic [31:0] m_saddr;
    logic [31:0] m_wdata;
    int          m_starve;
    logic [31:0] exp_if_rdata;
    logic [31:0] exp_mem_rdata;
    bit          ref_vld [256];
    logic [31:0] ref_dat [256];
    int          cyc;
    int          passed;
    int          total;

    function automatic logic [31:0] ref_read(input logic [31:0] sa);
        return ref_vld[sa[7:0]] ? ref_dat[sa[7:0]] : pattern(sa[7:0]);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total = total + 1;
        assert (obs === exp) passed = passed + 1;
        else $error("FAIL %s observed=0x%08h expected=0x%08h (cycle %0d)", tag, obs, exp, cyc);
    endtask

    task automatic model_reset();
        m_left        = 0;
        m_owner       = 0;
        m_saddr       = '0;
        m_wdata       = '0;
        m_starve      = 0;
        exp_if_rdata  = '0;
        exp_mem_rdata = '0;
    endtask

    // Advance the model across the coming clock edge using the driven inputs.
    task automatic model_step();
        int owner;
        bit grant;
        owner = 0;
        if (m_left > 0) begin
            if (m_left == 2) begin
                if (m_owner == 0) exp_if_rdata = ref_read(m_saddr);
                else if (m_owner == 1) exp_mem_rdata = ref_read(m_saddr);
            end
            m_left = m_left - 1;
        end else begin
            grant = 1'b1;
            if (GUARD && (m_starve == SMAX) && if_req) owner = 0;
            else if (mem_wr_req) owner = 2;
            else if (mem_rd_req) owner = 1;
            else if (if_req) owner = 0;
            else grant = 1'b0;
            if (grant) begin
                m_owner = owner;
                m_left  = W + 1;
                m_saddr = ((owner == 0) ? if_addr : mem_addr) >> 2;
                m_wdata = mem_wdata;
                if (owner == 2) begin
                    ref_vld[m_saddr[7:0]] = 1'b1;
                    ref_dat[m_saddr[7:0]] = mem_wdata;
                end
                m_starve = ((owner != 0) && if_req) ? m_starve + 1 : 0;
            end
        end
    endtask

    task automatic check_outputs();
        bit acc;
        bit done;
        acc  = (m_left >= 2);
        done = (m_left == 1);
        chk("busy",      32'(busy),      32'(m_left != 0));
        chk("ce_n",      32'(sram_ce_n), 32'(!acc));
        chk("oe_n",      32'(sram_oe_n), 32'(!(acc && m_owner != 2)));
        chk("we_n",      32'(sram_we_n), 32'(!(acc && m_owner == 2)));
        chk("if_ready",  32'(if_ready),  32'(done && m_owner == 0));
        chk("mem_ready", 32'(mem_ready), 32'(done && m_owner != 0));
        chk("if_rdata",  if_rdata,  exp_if_rdata);
        chk("mem_rdata", mem_rdata, exp_mem_rdata);
        if (acc) chk("sram_addr", sram_addr, m_saddr);
        if (acc && m_owner == 2) chk("sram_wdata", sram_wdata, m_wdata);
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        @(negedge clk);
        cyc = cyc + 1;
        check_outputs();
    endtask

    initial begin
        int we_low;
        int r1;
        int r2;
        int rm;
        int ri;
        int overlap;
        int nm;
        int ni;
        int npulse;
        int if_pos;

        passed = 0; total = 0; cyc = 0;
        rst = 1'b0;
        if_req = 1'b1; mem_rd_req = 1'b1; mem_wr_req = 1'b1;
        if_addr = 32'h0000_0008; mem_addr = 32'h0000_0200; mem_wdata = 32'h0BAD_F00D;
        model_reset();

        // Reset held with every request high.
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_outputs();
            chk("rst_sram_addr",  sram_addr,  32'h0);
            chk("rst_sram_wdata", sram_wdata, 32'h0);
        end
        rst = 1'b1;
        tick();
        chk("first_grant_is_write", 32'(sram_we_n), 32'h0);
        if_req = 1'b0; mem_rd_req = 1'b0; mem_wr_req = 1'b0;
        for (int i = 0; i < W + 1; i++) tick();

        // Single IF read.
        if_req = 1'b1; if_addr = 32'h0000_0010;
        tick();
        chk("ifrd_sram_addr", sram_addr, 32'h4);
        chk("ifrd_oe_n_1", 32'(sram_oe_n), 32'h0);
        tick();
        chk("ifrd_oe_n_2", 32'(sram_oe_n), 32'h0);
        tick();
        chk("ifrd_ready", 32'(if_ready), 32'h1);
        chk("ifrd_data", if_rdata, 32'hE3A0_1005);
        if_req = 1'b0;
        tick();

        // Store then load of the same word.
        mem_wr_req = 1'b1; mem_addr = 32'h0000_0100; mem_wdata = 32'hDEAD_BEEF;
        we_low = 0; r1 = -1; r2 = -1;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (!sram_we_n) we_low = we_low + 1;
            if (mem_ready) begin
                if (r1 < 0) begin
                    r1 = cyc; mem_wr_req = 1'b0; mem_rd_req = 1'b1;
                end else if (r2 < 0) begin
                    r2 = cyc; mem_rd_req = 1'b0;
                end
            end
        end
        chk("st_we_low_cycles", 32'(we_low), 32'd2);
        chk("st_ld_ready_gap", 32'(r2 - r1), 32'd4);
        chk("ld_data", mem_rdata, 32'hDEAD_BEEF);

        // Same-cycle IF and MEM load.
        if_req = 1'b1; if_addr = 32'h0000_0020;
        mem_rd_req = 1'b1; mem_addr = 32'h0000_0100;
        rm = -1; ri = -1; overlap = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (mem_ready && if_ready) overlap = overlap + 1;
            if (mem_ready && rm < 0) begin rm = cyc; mem_rd_req = 1'b0; end
            if (if_ready && ri < 0) begin ri = cyc; if_req = 1'b0; end
        end
        chk("cont_mem_first", 32'(rm >= 0 && rm < ri), 32'h1);
        chk("cont_if_gap", 32'(ri - rm), 32'd4);
        chk("cont_overlap", 32'(overlap), 32'd0);
        chk("cont_if_data", if_rdata, pattern(8'h08));

        // Reset in the last wait cycle of a store.
        mem_wr_req = 1'b1; mem_addr = 32'h0000_0040; mem_wdata = 32'h1234_5678;
        tick();
        tick();
        mem_wr_req = 1'b0;
        rst = 1'b0;
        #1;
        chk("abort_we_n", 32'(sram_we_n), 32'h1);
        chk("abort_ce_n", 32'(sram_ce_n), 32'h1);
        chk("abort_busy", 32'(busy), 32'h0);
        chk("abort_mem_ready", 32'(mem_ready), 32'h0);
        model_reset();
        @(posedge clk);
        @(negedge clk);
        check_outputs();
        rst = 1'b1;
        tick();
        chk("abort_idle_after", 32'(busy), 32'h0);

        // MEM load and IF held together for five slots.
        mem_rd_req = 1'b1; mem_addr = 32'h0000_0100;
        if_req = 1'b1; if_addr = 32'h0000_0010;
        nm = 0; ni = 0; npulse = 0; if_pos = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (mem_ready) begin nm = nm + 1; npulse = npulse + 1; end
            if (if_ready) begin ni = ni + 1; npulse = npulse + 1; if_pos = npulse; end
        end
        mem_rd_req = 1'b0; if_req = 1'b0;
        chk("starve_mem_pulses", 32'(nm), GUARD ? 32'd4 : 32'd5);
        chk("starve_if_pulses",  32'(ni), GUARD ? 32'd1 : 32'd0);
        chk("starve_if_slot",    32'(if_pos), GUARD ? 32'd5 : 32'd0);
        for (int i = 0; i < W + 1; i++) tick();

        // Random traffic.
        for (int i = 0; i < 600; i++) begin
            mem_wr_req = ($urandom_range(0, 3) == 0);
            mem_rd_req = ($urandom_range(0, 2) == 0);
            if_req     = ($urandom_range(0, 1) == 0);
            if_addr    = 32'($urandom_range(0, 1023));
            mem_addr   = 32'($urandom_range(0, 1023));
            mem_wdata  = $urandom;
            tick();
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
